// File: rtl/crc_pkg.sv
// Shared CRC definitions for the serial CRC generator and the frame checker.
// Both sides share one LFSR step function so their arithmetic cannot drift apart.
package crc_pkg;

  localparam int unsigned CRC_WIDTH_DEFAULT = 3;
  localparam logic [CRC_WIDTH_DEFAULT-1:0] POLY_DEFAULT = 3'b011;
  localparam int unsigned CRC_MAX_W = 32;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_DATA  = 2'd1;
  localparam state_t ST_CRC   = 2'd2;
  localparam state_t ST_CHECK = 2'd3;

  // One MSB-first LFSR step on a CRC of 'width' bits held in the low bits of a wide vector.
  function automatic logic [CRC_MAX_W-1:0] crc_next(input logic [CRC_MAX_W-1:0] crc,
                                                    input logic                 din,
                                                    input logic [CRC_MAX_W-1:0] poly,
                                                    input int unsigned          width);
    logic                 fb;
    logic [CRC_MAX_W-1:0] mask;
    mask = {CRC_MAX_W{1'b1}} >> (CRC_MAX_W - width);
    fb   = crc[width-1] ^ din;
    return ((crc << 1) ^ (fb ? poly : '0)) & mask;
  endfunction

endpackage

// File: rtl/crc_frame_checker_if.sv
// Serial link plus result bus between the CRC frame checker and its neighbours.
interface crc_frame_checker_if
  import crc_pkg::*;
#(
  parameter int unsigned CRC_WIDTH = CRC_WIDTH_DEFAULT,
  parameter int unsigned ERR_CNT_W = 8
);
  logic                 data_in;
  logic                 wr_en;
  logic                 crc_valid;
  logic                 crc_ok;
  logic                 crc_err;
  logic [CRC_WIDTH-1:0] crc_calc;
  logic                 frame_abort;
  logic                 busy;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output data_in, wr_en,
    input  crc_valid, crc_ok, crc_err, crc_calc, frame_abort, busy, err_count
  );

  modport slave (
    input  data_in, wr_en,
    output crc_valid, crc_ok, crc_err, crc_calc, frame_abort, busy, err_count
  );
endinterface

// File: rtl/crc_lfsr.sv
// Serial CRC register: optional parallel re-init merged with a one-bit LFSR step.
module crc_lfsr
  import crc_pkg::*;
#(
  parameter int unsigned      WIDTH = CRC_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(POLY_DEFAULT),
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             init_i,
  input  logic             en_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] crc_o
);

  logic [WIDTH-1:0]     crc_q, crc_d, base;
  logic [CRC_MAX_W-1:0] step;

  // Init and step in the same cycle lets a frame's first bit be absorbed on arrival.
  always_comb begin
    base  = init_i ? INIT : crc_q;
    step  = crc_next(CRC_MAX_W'(base), bit_i, CRC_MAX_W'(POLY), WIDTH);
    crc_d = en_i ? step[WIDTH-1:0] : base;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) crc_q <= INIT;
    else       crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/crc_frame_checker.sv
// Receive-side CRC checker: recomputes the CRC of a serial frame, compares it with the
// trailing CRC bits, flags stalled frames and keeps a saturating error count.
module crc_frame_checker
  import crc_pkg::*;
#(
  parameter int unsigned          DATA_BITS = 9,
  parameter int unsigned          CRC_WIDTH = CRC_WIDTH_DEFAULT,
  parameter logic [CRC_WIDTH-1:0] POLY      = CRC_WIDTH'(POLY_DEFAULT),
  parameter logic [CRC_WIDTH-1:0] CRC_INIT  = '0,
  parameter int unsigned          TIMEOUT   = 16,
  parameter int unsigned          ERR_CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  crc_frame_checker_if.slave link_io
);

  localparam int unsigned MAX_BITS = (DATA_BITS > CRC_WIDTH) ? DATA_BITS : CRC_WIDTH;
  localparam int unsigned CNT_W    = $clog2(MAX_BITS + 1);
  localparam int unsigned IDLE_W   = $clog2(TIMEOUT + 1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
  logic [CRC_WIDTH-1:0] rx_crc_q, rx_crc_d, rx_crc_full;
  logic [CRC_WIDTH-1:0] calc_q, calc_d, crc;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 valid_q, valid_d, ok_q, ok_d, err_q, err_d, abort_q, abort_d;
  logic                 frame_start, lfsr_en, in_frame;

  crc_lfsr #(
    .WIDTH (CRC_WIDTH),
    .POLY  (POLY),
    .INIT  (CRC_INIT)
  ) u_lfsr (
    .clk_i  (clk),
    .rst_i  (rst),
    .init_i (frame_start),
    .en_i   (lfsr_en),
    .bit_i  (link_io.data_in),
    .crc_o  (crc)
  );

  assign in_frame = (state_q == ST_DATA) || (state_q == ST_CRC);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    rx_crc_d    = rx_crc_q;
    calc_d      = calc_q;
    err_cnt_d   = err_cnt_q;
    valid_d     = 1'b0;
    ok_d        = 1'b0;
    err_d       = 1'b0;
    abort_d     = 1'b0;
    frame_start = 1'b0;
    lfsr_en     = 1'b0;
    rx_crc_full = (rx_crc_q << 1) | CRC_WIDTH'(link_io.data_in);

    case (state_q)
      ST_DATA: begin
        if (link_io.wr_en) begin
          lfsr_en    = 1'b1;
          idle_cnt_d = '0;
          if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = ST_CRC;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_CRC: begin
        if (link_io.wr_en) begin
          rx_crc_d   = rx_crc_full;
          idle_cnt_d = '0;
          if (bit_cnt_q == CNT_W'(CRC_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = ST_CHECK;
            valid_d   = 1'b1;
            ok_d      = (crc == rx_crc_full);
            err_d     = !ok_d;
            calc_d    = crc;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        // IDLE and CHECK both accept the next frame's first payload bit.
        state_d = ST_IDLE;
        if (link_io.wr_en) begin
          frame_start = 1'b1;
          lfsr_en     = 1'b1;
          idle_cnt_d  = '0;
          if (DATA_BITS == 1) begin
            state_d   = ST_CRC;
            bit_cnt_d = '0;
          end else begin
            state_d   = ST_DATA;
            bit_cnt_d = CNT_W'(1);
          end
        end
      end
    endcase

    if (in_frame && !link_io.wr_en) begin
      if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
        abort_d    = 1'b1;
        state_d    = ST_IDLE;
        idle_cnt_d = '0;
        bit_cnt_d  = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
      end
    end

    if ((err_d || abort_d) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      idle_cnt_q <= '0;
      rx_crc_q   <= '0;
      calc_q     <= '0;
      err_cnt_q  <= '0;
      valid_q    <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      rx_crc_q   <= rx_crc_d;
      calc_q     <= calc_d;
      err_cnt_q  <= err_cnt_d;
      valid_q    <= valid_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      abort_q    <= abort_d;
    end
  end

  assign link_io.crc_valid   = valid_q;
  assign link_io.crc_ok      = ok_q;
  assign link_io.crc_err     = err_q;
  assign link_io.crc_calc    = calc_q;
  assign link_io.frame_abort = abort_q;
  assign link_io.busy        = in_frame;
  assign link_io.err_count   = err_cnt_q;

endmodule

// File: tb/tb_crc_frame_checker.sv
// Directed bench for crc_frame_checker: good/bad frames, gaps, back-to-back, timeout,
// mid-frame reset and error-counter saturation, with hand-computed CRCs.
module tb_crc_frame_checker;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [8:0] good_pay = 9'b011100110;

  always #5 clk = ~clk;

  crc_frame_checker_if #(.CRC_WIDTH(3), .ERR_CNT_W(8)) link ();

  crc_frame_checker #(
    .DATA_BITS (9),
    .CRC_WIDTH (3),
    .POLY      (3'b011),
    .CRC_INIT  (3'b000),
    .TIMEOUT   (16),
    .ERR_CNT_W (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .link_io (link.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the CHECK cycle with wr_en still high.
  task automatic send_frame(input logic [8:0] pay, input logic [2:0] crc, input int gap_max);
    logic [11:0] bits;
    int          g;
    bits = {pay, crc};
    for (int i = 11; i >= 0; i--) begin
      if (i < 11 && gap_max > 0) begin
        g = $urandom_range(gap_max, 0);
        if (g > 0) begin
          link.wr_en = 1'b0;
          repeat (g) @(negedge clk);
        end
      end
      link.wr_en   = 1'b1;
      link.data_in = bits[i];
      @(negedge clk);
    end
  endtask

  task automatic expect_result(input string tag, input logic ok, input logic [2:0] calc,
                               input logic [7:0] cnt);
    check({tag, ".valid"}, 32'(link.crc_valid), 32'd1);
    check({tag, ".ok"},    32'(link.crc_ok),    32'(ok));
    check({tag, ".err"},   32'(link.crc_err),   32'(!ok));
    check({tag, ".calc"},  32'(link.crc_calc),  32'(calc));
    check({tag, ".cnt"},   32'(link.err_count), 32'(cnt));
  endtask

  initial begin
    link.wr_en   = 1'b0;
    link.data_in = 1'b0;
    rst          = 1'b1;
    #12;
    check("rst.valid", 32'(link.crc_valid),   32'd0);
    check("rst.busy",  32'(link.busy),        32'd0);
    check("rst.abort", 32'(link.frame_abort), 32'd0);
    check("rst.calc",  32'(link.crc_calc),    32'd0);
    check("rst.cnt",   32'(link.err_count),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    send_frame(good_pay, 3'b100, 0);
    expect_result("good", 1'b1, 3'b100, 8'd0);
    link.wr_en = 1'b0;
    @(negedge clk);
    check("good.pulse_end", 32'(link.crc_valid), 32'd0);
    check("good.ok_clear",  32'(link.crc_ok),    32'd0);
    check("good.calc_hold", 32'(link.crc_calc),  32'b100);

    send_frame(good_pay, 3'b101, 0);
    expect_result("badcrc", 1'b0, 3'b100, 8'd1);
    send_frame(9'b111100110, 3'b100, 0);
    expect_result("badpay", 1'b0, 3'b010, 8'd2);
    link.wr_en = 1'b0;
    @(negedge clk);

    send_frame(good_pay, 3'b100, 15);
    expect_result("gap", 1'b1, 3'b100, 8'd2);
    send_frame(good_pay, 3'b100, 0);
    expect_result("b2b", 1'b1, 3'b100, 8'd2);
    link.wr_en = 1'b0;
    @(negedge clk);
    check("b2b.pulse_end", 32'(link.crc_valid), 32'd0);

    for (int i = 0; i < 5; i++) begin
      link.wr_en   = 1'b1;
      link.data_in = good_pay[8-i];
      @(negedge clk);
    end
    check("to.busy", 32'(link.busy), 32'd1);
    link.wr_en = 1'b0;
    repeat (15) @(negedge clk);
    check("to.early_abort", 32'(link.frame_abort), 32'd0);
    check("to.early_busy",  32'(link.busy),        32'd1);
    @(negedge clk);
    check("to.abort", 32'(link.frame_abort), 32'd1);
    check("to.idle",  32'(link.busy),        32'd0);
    check("to.valid", 32'(link.crc_valid),   32'd0);
    check("to.cnt",   32'(link.err_count),   32'd3);
    @(negedge clk);
    check("to.pulse_end", 32'(link.frame_abort), 32'd0);
    check("to.no_valid",  32'(link.crc_valid),   32'd0);
    send_frame(good_pay, 3'b100, 0);
    expect_result("after_to", 1'b1, 3'b100, 8'd3);
    link.wr_en = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      link.wr_en   = 1'b1;
      link.data_in = good_pay[8-i];
      @(negedge clk);
    end
    check("mid.busy", 32'(link.busy), 32'd1);
    link.wr_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid.busy0",  32'(link.busy),        32'd0);
    check("mid.cnt0",   32'(link.err_count),   32'd0);
    check("mid.calc0",  32'(link.crc_calc),    32'd0);
    check("mid.valid0", 32'(link.crc_valid),   32'd0);
    check("mid.abort0", 32'(link.frame_abort), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_frame(good_pay, 3'b100, 0);
    expect_result("after_rst", 1'b1, 3'b100, 8'd0);

    repeat (255) send_frame(good_pay, 3'b101, 0);
    expect_result("sat255", 1'b0, 3'b100, 8'hFF);
    send_frame(good_pay, 3'b101, 0);
    expect_result("sat256", 1'b0, 3'b100, 8'hFF);
    link.wr_en = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crc_frame_checker.md
Name: crc_frame_checker

Overview:
- Receive-side counterpart of the serial CRC generator; sits directly downstream of it on the serial link.
- Consumes a serial frame qualified by wr_en: DATA_BITS payload bits MSB-first, then CRC_WIDTH CRC bits MSB-first.
- Recomputes the CRC over the payload, compares it with the received CRC, and reports a one-cycle pass/fail result.
- Also flags stalled frames and keeps a saturating error count.

Parameters:
- DATA_BITS, 9, payload bits per frame (≥1).
- CRC_WIDTH, 3, CRC register width.
- POLY, 3'b011, generator low-order taps; implicit x^CRC_WIDTH term (default is x^3+x+1).
- CRC_INIT, 3'b000, CRC register value at frame start; no final XOR.
- TIMEOUT, 16, maximum idle cycles between wr_en pulses inside a frame.
- ERR_CNT_W, 8, width of err_count.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  1  serial bit; sampled only when wr_en=1.
- wr_en  input  1  bit-valid strobe; one bit per cycle high.
- crc_valid  output  1  one-cycle pulse: frame result available.
- crc_ok  output  1  received CRC equals computed; valid while crc_valid=1, else 0.
- crc_err  output  1  mismatch; valid while crc_valid=1, else 0.
- crc_calc  output  CRC_WIDTH  computed CRC of last completed frame; held until next result.
- frame_abort  output  1  one-cycle pulse: frame abandoned on timeout.
- busy  output  1  high in DATA or CRC state.
- err_count  output  ERR_CNT_W  count of crc_err plus frame_abort events; saturates at all-ones.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; all outputs 0; CRC register=CRC_INIT; counters=0.
- FSM states: IDLE, DATA, CRC, CHECK.
- IDLE: on wr_en, sample the bit as payload bit 0, update the CRC, set bit_cnt=1, go to DATA. If DATA_BITS=1, go straight to CRC.
- DATA: each wr_en updates the CRC LFSR: fb = crc[MSB]^data_in; crc = (crc<<1) ^ (fb ? POLY : 0). After payload bit DATA_BITS-1 is sampled, clear bit_cnt and go to CRC.
- CRC: each wr_en shifts data_in into rx_crc MSB-first; the CRC register is frozen. After CRC bit CRC_WIDTH-1 is sampled, go to CHECK.
- CHECK (exactly one cycle): register crc_valid=1, crc_ok=(crc==rx_crc), crc_err=!crc_ok, crc_calc=crc.
  - Latency: result visible the cycle after the edge that sampled the final CRC bit.
  - A wr_en during CHECK starts the next frame: it is treated as payload bit 0, exactly as from IDLE (back-to-back frames, no lost bits).
  - CRC register re-initialises to CRC_INIT at every frame start.
- Timeout: in DATA/CRC, idle_cnt counts consecutive cycles with wr_en=0 and clears on wr_en. When it reaches TIMEOUT: pulse frame_abort for one cycle, increment err_count, go to IDLE. No crc_valid is issued for an aborted frame.
- err_count increments by 1 per crc_err or frame_abort; never wraps.
- busy=1 in DATA and CRC only.
- rst mid-frame discards the partial frame with no result pulse.
- wr_en held high continuously is legal: one bit per cycle.

Decomposition:
- Shared package crc_pkg holds:
  - CRC_WIDTH and POLY defaults, shared with the CRC generator.
  - state encoding enum (IDLE/DATA/CRC/CHECK).
  - crc_next(crc, bit) function, so generator and checker use identical LFSR arithmetic.
- One natural sub-module: crc_lfsr (parallel-load init, enable, serial bit in, CRC_WIDTH out). The same block is reusable inside the generator.

Test Plan:
- Good frame: payload 011100110 followed by CRC 100, wr_en continuous from the reset-release idle state -> one crc_valid pulse, crc_ok=1, crc_calc=3'b100, err_count=0.
- Bad CRC: payload 011100110 followed by CRC 101 -> crc_err=1, crc_calc=3'b100, err_count=1.
- Payload bit error: payload 111100110 followed by CRC 100 -> crc_err=1, crc_calc=3'b010.
- Gapped and back-to-back frames: good frame with random 0–15-cycle wr_en gaps -> crc_ok; then a second good frame starting in the CHECK cycle -> second crc_ok, no bit lost.
- Timeout: wr_en stops after 5 payload bits for 16 cycles -> frame_abort pulse, busy=0, err_count increments, no crc_valid. Next good frame still passes.
- Reset mid-frame: assert rst asynchronously after 4 payload bits -> all outputs 0 immediately. Subsequent good frame -> crc_ok. Force 256 errors -> err_count saturates at 8'hFF.
